rob_release_ctrl: RTL and testbench

In-order release controller for the read-reorder path. It records issued read bursts as {uid, original ID, length} in an issue-order FIFO. For the oldest outstanding burst it drives `free_req`/`uid_to_free` into the per-UID response memory, then streams the popped beats to the master with the UID remapped to the original AXI ID. When a burst completes it returns the UID to the allocator and flags length/last mismatches.

---
 rtl/rob_release_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_rob_release_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_release_ctrl.sv
// rob_release_ctrl
//
// In-order release controller for the read-reorder path. Issued read bursts are
// recorded as {uid, orig_id, len} in an issue-order FIFO. The oldest burst is
// popped into a streaming slot, which requests its beats from the per-UID
// response memory (free_req/uid_to_free) and passes them to the master with
// the UID replaced by the original AXI ID. When the last beat (by length count)
// is accepted, the UID is handed back to the allocator. A mismatch between the
// memory's last flag and the counted last beat raises a sticky protocol_err.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   ord_push_valid/ready          burst issue handshake into the order FIFO
//   ord_push_uid/orig_id/len      issued burst descriptor
//   free_req, uid_to_free         pop request towards the response memory
//   mem_r_valid/data/resp/last    head beat of the response memory
//   mem_r_ready                   beat accepted (memory pop)
//   m_rvalid/rready               master R handshake
//   m_rid/rdata/rresp/rlast       master R payload
//   uid_release_valid/uid_release one-cycle UID return pulse
//   protocol_err, err_clr         sticky last-mismatch flag and its clear

module rob_release_ctrl #(
    parameter int unsigned NUM_UIDS      = 16,
    parameter int unsigned ID_WIDTH      = $clog2(NUM_UIDS),
    parameter int unsigned ORIG_ID_WIDTH = 4,
    parameter int unsigned DATA_WIDTH    = 64,
    parameter int unsigned RESP_WIDTH    = 2,
    parameter int unsigned LEN_WIDTH     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,

    input  logic                     ord_push_valid,
    output logic                     ord_push_ready,
    input  logic [ID_WIDTH-1:0]      ord_push_uid,
    input  logic [ORIG_ID_WIDTH-1:0] ord_push_orig_id,
    input  logic [LEN_WIDTH-1:0]     ord_push_len,

    output logic                     free_req,
    output logic [ID_WIDTH-1:0]      uid_to_free,

    input  logic                     mem_r_valid,
    input  logic [DATA_WIDTH-1:0]    mem_r_data,
    input  logic [RESP_WIDTH-1:0]    mem_r_resp,
    input  logic                     mem_r_last,
    output logic                     mem_r_ready,

    output logic                     m_rvalid,
    input  logic                     m_rready,
    output logic [ORIG_ID_WIDTH-1:0] m_rid,
    output logic [DATA_WIDTH-1:0]    m_rdata,
    output logic [RESP_WIDTH-1:0]    m_rresp,
    output logic                     m_rlast,

    output logic                     uid_release_valid,
    output logic [ID_WIDTH-1:0]      uid_release,

    output logic                     protocol_err,
    input  logic                     err_clr
);

    localparam int unsigned CNT_WIDTH = $clog2(NUM_UIDS + 1);
    localparam logic [ID_WIDTH-1:0]  LAST_PTR = ID_WIDTH'(NUM_UIDS - 1);
    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(NUM_UIDS);

    typedef enum logic [0:0] {StIdle, StStream} state_e;

    // ------------------------------------------------------------------
    // Order FIFO
    // ------------------------------------------------------------------
    logic [ID_WIDTH-1:0]      fifo_uid_q  [NUM_UIDS];
    logic [ORIG_ID_WIDTH-1:0] fifo_orig_q [NUM_UIDS];
    logic [LEN_WIDTH-1:0]     fifo_len_q  [NUM_UIDS];

    logic [ID_WIDTH-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_WIDTH-1:0] count_q;
    logic                 fifo_full, fifo_empty;
    logic                 push, pop;

    state_e               state_q;

    assign fifo_full      = (count_q == FULL_CNT);
    assign fifo_empty     = (count_q == '0);
    assign ord_push_ready = !fifo_full;
    assign push           = ord_push_valid && !fifo_full;
    assign pop            = (state_q == StIdle) && !fifo_empty;

    // Payload storage carries no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_uid_q[wr_ptr_q]  <= ord_push_uid;
            fifo_orig_q[wr_ptr_q] <= ord_push_orig_id;
            fifo_len_q[wr_ptr_q]  <= ord_push_len;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Release FSM
    // ------------------------------------------------------------------
    logic [ID_WIDTH-1:0]      cur_uid_q;
    logic [ORIG_ID_WIDTH-1:0] cur_orig_q;
    logic [LEN_WIDTH-1:0]     cur_len_q;
    // One bit wider than len so that len=all-ones cannot wrap the counter.
    logic [LEN_WIDTH:0]       beat_cnt_q;

    logic streaming, beat_hs, last_beat, err_set;

    assign streaming = (state_q == StStream);
    assign beat_hs   = streaming && mem_r_valid && m_rready;
    assign last_beat = (beat_cnt_q == {1'b0, cur_len_q});
    // Memory's last flag is checked against the count but never ends a burst.
    assign err_set   = beat_hs && (mem_r_last != last_beat);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= StIdle;
            cur_uid_q         <= '0;
            cur_orig_q        <= '0;
            cur_len_q         <= '0;
            beat_cnt_q        <= '0;
            uid_release_valid <= 1'b0;
            uid_release       <= '0;
            protocol_err      <= 1'b0;
        end else begin
            uid_release_valid <= 1'b0;
            uid_release       <= '0;

            // Setting wins over clearing in the same cycle.
            if (err_set) begin
                protocol_err <= 1'b1;
            end else if (err_clr) begin
                protocol_err <= 1'b0;
            end

            case (state_q)
                StIdle: begin
                    if (!fifo_empty) begin
                        cur_uid_q  <= fifo_uid_q[rd_ptr_q];
                        cur_orig_q <= fifo_orig_q[rd_ptr_q];
                        cur_len_q  <= fifo_len_q[rd_ptr_q];
                        beat_cnt_q <= '0;
                        state_q    <= StStream;
                    end
                end
                StStream: begin
                    if (beat_hs) begin
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                        if (last_beat) begin
                            state_q           <= StIdle;
                            uid_release_valid <= 1'b1;
                            uid_release       <= cur_uid_q;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Beat path is purely combinational: no added latency to the master.
    always_comb begin
        free_req    = 1'b0;
        uid_to_free = '0;
        mem_r_ready = 1'b0;
        m_rvalid    = 1'b0;
        m_rid       = '0;
        m_rdata     = '0;
        m_rresp     = '0;
        m_rlast     = 1'b0;
        if (streaming) begin
            free_req    = 1'b1;
            uid_to_free = cur_uid_q;
            mem_r_ready = m_rready;
            m_rvalid    = mem_r_valid;
            m_rid       = cur_orig_q;
            m_rdata     = mem_r_data;
            m_rresp     = mem_r_resp;
            m_rlast     = last_beat;
        end
    end

endmodule

// File: tb/tb_rob_release_ctrl.sv
// Randomized bench for rob_release_ctrl. The bench plays both the issuing side
// and the response memory, and predicts every output from a burst-level model:
// a queue of outstanding bursts in push order, the index of the beat currently
// expected, and a sticky error bit.

module tb_rob_release_ctrl;

    localparam int NU = 16;
    localparam int IW = 4;
    localparam int OW = 4;
    localparam int DW = 64;
    localparam int RW = 2;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ord_push_valid = 1'b0;
    logic          ord_push_ready;
    logic [IW-1:0] ord_push_uid = '0;
    logic [OW-1:0] ord_push_orig_id = '0;
    logic [LW-1:0] ord_push_len = '0;
    logic          free_req;
    logic [IW-1:0] uid_to_free;
    logic          mem_r_valid = 1'b0;
    logic [DW-1:0] mem_r_data = '0;
    logic [RW-1:0] mem_r_resp = '0;
    logic          mem_r_last = 1'b0;
    logic          mem_r_ready;
    logic          m_rvalid;
    logic          m_rready = 1'b0;
    logic [OW-1:0] m_rid;
    logic [DW-1:0] m_rdata;
    logic [RW-1:0] m_rresp;
    logic          m_rlast;
    logic          uid_release_valid;
    logic [IW-1:0] uid_release;
    logic          protocol_err;
    logic          err_clr = 1'b0;

    always #5 clk = ~clk;

    rob_release_ctrl #(
        .NUM_UIDS      (NU),
        .ID_WIDTH      (IW),
        .ORIG_ID_WIDTH (OW),
        .DATA_WIDTH    (DW),
        .RESP_WIDTH    (RW),
        .LEN_WIDTH     (LW)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .ord_push_valid    (ord_push_valid),
        .ord_push_ready    (ord_push_ready),
        .ord_push_uid      (ord_push_uid),
        .ord_push_orig_id  (ord_push_orig_id),
        .ord_push_len      (ord_push_len),
        .free_req          (free_req),
        .uid_to_free       (uid_to_free),
        .mem_r_valid       (mem_r_valid),
        .mem_r_data        (mem_r_data),
        .mem_r_resp        (mem_r_resp),
        .mem_r_last        (mem_r_last),
        .mem_r_ready       (mem_r_ready),
        .m_rvalid          (m_rvalid),
        .m_rready          (m_rready),
        .m_rid             (m_rid),
        .m_rdata           (m_rdata),
        .m_rresp           (m_rresp),
        .m_rlast           (m_rlast),
        .uid_release_valid (uid_release_valid),
        .uid_release       (uid_release),
        .protocol_err      (protocol_err),
        .err_clr           (err_clr)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [IW-1:0] uid;
        logic [OW-1:0] orig;
        logic [LW-1:0] len;
        logic [5:0]    slot;
    } burst_t;

    burst_t        bq[$];        // outstanding bursts, push order; head may be streaming
    bit            busy;         // head burst is being streamed
    int            beat;         // next beat index of the head burst
    bit            exp_err;
    bit            rel_pend;
    logic [IW-1:0] rel_uid;
    logic [5:0]    next_slot;

    // Response-memory contents, one row per burst slot.
    logic [DW-1:0] mdata [64][256];
    logic [RW-1:0] mresp [64][256];
    logic          mlast [64][256];

    int push_pct, mem_pct, rdy_pct;

    task automatic model_reset();
        bq.delete();
        busy     = 1'b0;
        beat     = 0;
        exp_err  = 1'b0;
        rel_pend = 1'b0;
        rel_uid  = '0;
    endtask

    task automatic run_cycle(input bit do_reset);
        burst_t h;
        bit     exp_ready, take, hs, pushed, is_last, err_n, rel_n;
        int     r;
        logic [LW-1:0] plen;

        @(posedge clk);
        #1;
        if (do_reset) begin
            rst_n = 1'b0;
            model_reset();
        end else begin
            rst_n = 1'b1;
        end

        // Issue side
        r = $urandom_range(99);
        if (r < 60)      plen = LW'($urandom_range(3));
        else if (r < 85) plen = LW'($urandom_range(15, 4));
        else if (r < 95) plen = '0;
        else             plen = 8'd255;
        ord_push_valid   = !do_reset && ($urandom_range(99) < push_pct);
        ord_push_uid     = IW'($urandom_range(NU - 1));
        ord_push_orig_id = OW'($urandom_range(15));
        ord_push_len     = plen;
        m_rready         = ($urandom_range(99) < rdy_pct);
        err_clr          = ($urandom_range(99) < 4);

        // Response memory: serves the head burst; junk otherwise to probe gating.
        if (busy) begin
            h           = bq[0];
            mem_r_valid = ($urandom_range(99) < mem_pct);
            mem_r_data  = mdata[h.slot][beat];
            mem_r_resp  = mresp[h.slot][beat];
            mem_r_last  = mlast[h.slot][beat];
        end else begin
            mem_r_valid = !do_reset && ($urandom_range(99) < 20);
            mem_r_data  = {$urandom, $urandom};
            mem_r_resp  = RW'($urandom_range(3));
            mem_r_last  = $urandom_range(1) == 1;
        end

        @(negedge clk);
        exp_ready = (bq.size() - int'(busy)) < NU;
        check_eq("ord_push_ready", ord_push_ready, exp_ready);
        check_eq("free_req", free_req, busy);
        check_eq("m_rvalid", m_rvalid, busy && mem_r_valid);
        check_eq("mem_r_ready", mem_r_ready, busy && m_rready);
        if (busy) begin
            h = bq[0];
            check_eq("uid_to_free", uid_to_free, h.uid);
            if (mem_r_valid) begin
                check_eq("m_rid", m_rid, h.orig);
                check_eq("m_rdata", m_rdata, mdata[h.slot][beat]);
                check_eq("m_rresp", m_rresp, mresp[h.slot][beat]);
                check_eq("m_rlast", m_rlast, beat == int'(h.len));
            end
        end else begin
            check_eq("idle_rdata", m_rdata, '0);
            check_eq("idle_rid_rresp_rlast", {m_rid, m_rresp, m_rlast}, '0);
        end
        if (!rst_n) check_eq("rst_uid_to_free", uid_to_free, '0);
        check_eq("uid_release_valid", uid_release_valid, rel_pend);
        if (rel_pend) check_eq("uid_release", uid_release, rel_uid);
        check_eq("protocol_err", protocol_err, exp_err);

        if (!rst_n) return;

        // Advance the model across the coming edge.
        take   = !busy && bq.size() > 0;
        hs     = busy && mem_r_valid && m_rready;
        pushed = ord_push_valid && exp_ready;
        err_n  = exp_err;
        rel_n  = 1'b0;
        if (err_clr) err_n = 1'b0;
        if (hs) begin
            h       = bq[0];
            is_last = (beat == int'(h.len));
            if (mem_r_last != is_last) err_n = 1'b1;
            beat++;
            if (is_last) begin
                rel_n   = 1'b1;
                rel_uid = h.uid;
                busy    = 1'b0;
                void'(bq.pop_front());
            end
        end
        if (take) begin
            busy = 1'b1;
            beat = 0;
        end
        if (pushed) begin
            h.uid  = ord_push_uid;
            h.orig = ord_push_orig_id;
            h.len  = ord_push_len;
            h.slot = next_slot;
            next_slot++;
            for (int i = 0; i <= int'(h.len); i++) begin
                mdata[h.slot][i] = {$urandom, $urandom};
                mresp[h.slot][i] = RW'($urandom_range(3));
                // Occasionally misplace the memory's last flag.
                mlast[h.slot][i] = (i == int'(h.len)) ^ ($urandom_range(99) < 3);
            end
            bq.push_back(h);
        end
        exp_err  = err_n;
        rel_pend = rel_n;
    endtask

    task automatic run_phase(input int cycles, input int p_push, input int p_mem,
                             input int p_rdy);
        push_pct = p_push;
        mem_pct  = p_mem;
        rdy_pct  = p_rdy;
        for (int i = 0; i < cycles; i++) run_cycle(1'b0);
    endtask

    initial begin
        next_slot = '0;
        push_pct  = 0;
        mem_pct   = 0;
        rdy_pct   = 0;
        model_reset();
        for (int i = 0; i < 3; i++) run_cycle(1'b1);

        run_phase(1500, 30, 70, 80);   // steady traffic
        run_phase(400, 95, 3, 50);     // issue flood, slow memory: fills the FIFO
        run_phase(1000, 40, 80, 30);   // heavy master backpressure

        // Reset in the middle of a multi-beat burst.
        push_pct = 40;
        mem_pct  = 80;
        rdy_pct  = 60;
        for (int i = 0; i < 2000 && !(busy && beat >= 1); i++) run_cycle(1'b0);
        run_cycle(1'b1);

        run_phase(1500, 35, 75, 75);   // normal operation after reset
        run_phase(200, 0, 90, 90);     // drain

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
